axi_default_slave: RTL and testbench

// - Decode-error slave on the AXI bus. Terminates every transaction the address decoder routes to the default slot (ADDR[31:16] not 16'h0000/16'h0001).
// - Accepts AW/W/AR handshakes and drains write data. Answers every write and every read beat with DECERR, so an unmapped access never hangs a master.
// - Sits directly downstream of the decoder's VALID_SDEFAULT/READY_SDEFAULT pair and behind the slave-side ID widening (IDS).

---
 rtl/axi_default_slave_if.sv | 38 +++
 rtl/axi_default_slave.sv | 135 +++++++++++++
 tb/tb_axi_default_slave.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_default_slave_if.sv
// AXI bus bundle between the address decoder's default slot and the decode-error slave.
// The master modport drives requests; the slave modport drives ready signals and responses.
interface axi_default_slave_if #(
    parameter int ID_W   = 8,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic [ID_W-1:0]   AWID;
    logic              AWVALID;
    logic              AWREADY;
    logic              WVALID;
    logic              WLAST;
    logic              WREADY;
    logic [ID_W-1:0]   BID;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [ID_W-1:0]   ARID;
    logic [LEN_W-1:0]  ARLEN;
    logic              ARVALID;
    logic              ARREADY;
    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    modport slave (
        input  AWID, AWVALID, WVALID, WLAST, BREADY, ARID, ARLEN, ARVALID, RREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport master (
        output AWID, AWVALID, WVALID, WLAST, BREADY, ARID, ARLEN, ARVALID, RREADY,
        input  AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/axi_default_slave.sv
// Decode-error slave: accepts unmapped AXI accesses and answers every one with DECERR.
// Optional AXI_DS_ERRCNT_EN adds a saturating err_cnt output counting completed errors.
module axi_default_slave #(
    parameter int ID_W   = 8,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic ACLK,
    input  logic ARESET,
    axi_default_slave_if.slave bus
`ifdef AXI_DS_ERRCNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t         w_state;
    w_state_t         w_next;
    r_state_t         r_state;
    r_state_t         r_next;
    logic [ID_W-1:0]  bid_q;
    logic [ID_W-1:0]  rid_q;
    logic [LEN_W-1:0] cnt;
    logic             aw_hs;
    logic             ar_hs;
    logic             r_hs;

    assign aw_hs = bus.AWVALID && (w_state == W_IDLE);
    assign ar_hs = bus.ARVALID && (r_state == R_IDLE);
    assign r_hs  = bus.RREADY && (r_state == R_DATA);

    assign bus.BID   = bid_q;
    assign bus.BRESP = 2'b11;
    assign bus.RID   = rid_q;
    assign bus.RDATA = '0;
    assign bus.RRESP = 2'b11;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state <= W_IDLE;
            bid_q   <= '0;
        end else begin
            w_state <= w_next;
            if (aw_hs)
                bid_q <= bus.AWID;
        end
    end

    // Write beats are discarded; only WLAST ends the data phase.
    always_comb begin
        w_next      = w_state;
        bus.AWREADY = 1'b0;
        bus.WREADY  = 1'b0;
        bus.BVALID  = 1'b0;
        case (w_state)
            W_IDLE: begin
                bus.AWREADY = 1'b1;
                if (bus.AWVALID)
                    w_next = W_DATA;
            end
            W_DATA: begin
                bus.WREADY = 1'b1;
                if (bus.WVALID && bus.WLAST)
                    w_next = W_RESP;
            end
            W_RESP: begin
                bus.BVALID = 1'b1;
                if (bus.BREADY)
                    w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= R_IDLE;
            rid_q   <= '0;
            cnt     <= '0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                rid_q <= bus.ARID;
                cnt   <= bus.ARLEN;
            end else if (r_hs && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // cnt holds beats remaining after the current one, so ARLEN=15 gives 16 beats.
    always_comb begin
        r_next      = r_state;
        bus.ARREADY = 1'b0;
        bus.RVALID  = 1'b0;
        bus.RLAST   = 1'b0;
        case (r_state)
            R_IDLE: begin
                bus.ARREADY = 1'b1;
                if (bus.ARVALID)
                    r_next = R_DATA;
            end
            R_DATA: begin
                bus.RVALID = 1'b1;
                bus.RLAST  = (cnt == '0);
                if (bus.RREADY && (cnt == '0))
                    r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

`ifdef AXI_DS_ERRCNT_EN
    logic [15:0] err_cnt_q;
    logic        b_done;
    logic        r_done;
    logic [16:0] err_sum;

    assign b_done  = (w_state == W_RESP) && bus.BREADY;
    assign r_done  = r_hs && (cnt == '0);
    assign err_sum = {1'b0, err_cnt_q} + {16'd0, b_done} + {16'd0, r_done};
    assign err_cnt = err_cnt_q;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            err_cnt_q <= '0;
        else if (err_sum[16])
            err_cnt_q <= 16'hFFFF;
        else
            err_cnt_q <= err_sum[15:0];
    end
`endif
endmodule

// File: tb/tb_axi_default_slave.sv
// Scoreboard bench for axi_default_slave: expected B and R responses are queued at request time
// and popped as the DUT completes handshakes; inputs change and outputs are sampled on negedge.
module tb_axi_default_slave;
    localparam int ID_W   = 8;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            last;
    } rbeat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    rbeat_t          rq[$];
    logic [ID_W-1:0] wq[$];

    always #5 clk = ~clk;

    axi_default_slave_if #(.ID_W(ID_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

`ifdef AXI_DS_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    axi_default_slave #(.ID_W(ID_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .bus    (bus)
`ifdef AXI_DS_ERRCNT_EN
        ,
        .err_cnt(err_cnt)
`endif
    );

    task automatic init_bus();
        bus.AWID = '0; bus.AWVALID = 1'b0;
        bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.BREADY = 1'b0;
        bus.ARID = '0; bus.ARLEN = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    endtask

    task automatic run_write(input logic [ID_W-1:0] id, input int beats, input int stall);
        logic            ok;
        logic [ID_W-1:0] exp_id;
        bus.AWID = id;
        bus.AWVALID = 1'b1;
        wq.push_back(id);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.AWREADY) begin ok = 1'b1; @(negedge clk); break; end
            @(negedge clk);
        end
        bus.AWVALID = 1'b0;
        tests_run++;
        if (!ok || bus.WREADY !== 1'b1 || bus.AWREADY !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL aw_accept: got ok=%b wready=%b awready=%b, expected 1 1 0", ok, bus.WREADY, bus.AWREADY);
        end
        for (int b = 0; b < beats; b++) begin
            bus.WVALID = 1'b1;
            bus.WLAST = (b == beats - 1);
            ok = 1'b0;
            for (int i = 0; i < 50; i++) begin
                if (bus.WREADY) begin ok = 1'b1; @(negedge clk); break; end
                @(negedge clk);
            end
            if (!ok) begin
                tests_run++; tests_failed++;
                $display("[TB] FAIL w_timeout: got wready=0 for 50 cycles, expected 1");
            end
        end
        bus.WVALID = 1'b0;
        bus.WLAST = 1'b0;
        tests_run++;
        if (bus.BVALID !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bvalid_after_wlast: got %b expected 1", bus.BVALID);
        end
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            tests_run++;
            if (bus.BVALID !== 1'b1 || bus.BID !== wq[0]) begin
                tests_failed++;
                $display("[TB] FAIL b_hold: got bvalid=%b bid=%h expected 1 %h", bus.BVALID, bus.BID, wq[0]);
            end
        end
        bus.BREADY = 1'b1;
        exp_id = (wq.size() > 0) ? wq.pop_front() : '0;
        tests_run++;
        if (bus.BVALID !== 1'b1 || bus.BID !== exp_id || bus.BRESP !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL b_resp: got bvalid=%b bid=%h bresp=%b expected 1 %h 11", bus.BVALID, bus.BID, bus.BRESP, exp_id);
        end
        @(negedge clk);
        bus.BREADY = 1'b0;
        tests_run++;
        if (bus.AWREADY !== 1'b1 || bus.BVALID !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL w_idle_after: got awready=%b bvalid=%b expected 1 0", bus.AWREADY, bus.BVALID);
        end
    endtask

    task automatic run_read(input logic [ID_W-1:0] id, input logic [LEN_W-1:0] len, input bit toggle);
        logic   ok;
        logic   done;
        int     got;
        rbeat_t exp;
        for (int b = 0; b <= int'(len); b++) begin
            exp.id = id;
            exp.last = (b == int'(len));
            rq.push_back(exp);
        end
        bus.ARID = id;
        bus.ARLEN = len;
        bus.ARVALID = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.ARREADY) begin ok = 1'b1; @(negedge clk); break; end
            @(negedge clk);
        end
        bus.ARVALID = 1'b0;
        tests_run++;
        if (!ok || bus.ARREADY !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ar_accept: got ok=%b arready=%b expected 1 0", ok, bus.ARREADY);
        end
        got = 0;
        done = 1'b0;
        for (int c = 0; c < 200 && !done && rq.size() > 0; c++) begin
            bus.RREADY = toggle ? (c % 2 == 0) : 1'b1;
            exp = rq[0];
            tests_run++;
            if (bus.RVALID !== 1'b1 || bus.RID !== exp.id || bus.RDATA !== '0 || bus.RRESP !== 2'b11 || bus.RLAST !== exp.last) begin
                tests_failed++;
                $display("[TB] FAIL r_beat: got vld=%b id=%h data=%h resp=%b last=%b, expected 1 %h 0 11 %b",
                         bus.RVALID, bus.RID, bus.RDATA, bus.RRESP, bus.RLAST, exp.id, exp.last);
            end
            if (bus.RREADY) begin
                void'(rq.pop_front());
                got++;
                if (exp.last) done = 1'b1;
            end
            @(negedge clk);
        end
        bus.RREADY = 1'b1;
        tests_run++;
        if (!done || got != int'(len) + 1) begin
            tests_failed++;
            $display("[TB] FAIL r_beat_count: got %0d expected %0d", got, int'(len) + 1);
        end
        tests_run++;
        if (bus.RVALID !== 1'b0 || bus.ARREADY !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL r_idle_after: got rvalid=%b arready=%b expected 0 1", bus.RVALID, bus.ARREADY);
        end
        @(negedge clk);
        bus.RREADY = 1'b0;
        rq.delete();
    endtask

    task automatic test_reset();
        init_bus();
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.AWREADY !== 1'b1 || bus.ARREADY !== 1'b1 || bus.WREADY !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready: got aw=%b ar=%b w=%b expected 1 1 0", bus.AWREADY, bus.ARREADY, bus.WREADY);
        end
        tests_run++;
        if (bus.BVALID !== 1'b0 || bus.RVALID !== 1'b0 || bus.RLAST !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_valid: got bvalid=%b rvalid=%b rlast=%b expected 0 0 0", bus.BVALID, bus.RVALID, bus.RLAST);
        end
        tests_run++;
        if (bus.BID !== '0 || bus.RID !== '0 || bus.BRESP !== 2'b11 || bus.RRESP !== 2'b11 || bus.RDATA !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_fields: got bid=%h rid=%h bresp=%b rresp=%b rdata=%h expected 00 00 11 11 0",
                     bus.BID, bus.RID, bus.BRESP, bus.RRESP, bus.RDATA);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        bus.WVALID = 1'b1;
        bus.WLAST = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.WREADY !== 1'b0 || bus.BVALID !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL w_before_aw: got wready=%b bvalid=%b expected 0 0", bus.WREADY, bus.BVALID);
        end
        bus.WVALID = 1'b0;
        bus.WLAST = 1'b0;
        @(negedge clk);
        run_write(8'h25, 1, 0);
    endtask

    task automatic test_read_burst();
        run_read(8'h13, 4'd3, 1'b0);
    endtask

    task automatic test_backpressure();
        run_read(8'h5A, 4'hF, 1'b1);
        run_write(8'h77, 2, 5);
    endtask

    task automatic test_overlap();
        fork
            run_write(8'hA1, 4, 0);
            run_read(8'hB2, 4'd1, 1'b0);
        join
    endtask

    task automatic test_aw_stall();
        logic [ID_W-1:0] exp_id;
        bus.AWID = 8'h40;
        bus.AWVALID = 1'b1;
        wq.push_back(8'h40);
        @(negedge clk);
        bus.AWID = 8'h41;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.AWREADY !== 1'b0 || bus.WREADY !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL aw_stall: got awready=%b wready=%b expected 0 1", bus.AWREADY, bus.WREADY);
        end
        bus.AWVALID = 1'b0;
        bus.WVALID = 1'b1;
        bus.WLAST = 1'b1;
        @(negedge clk);
        bus.WVALID = 1'b0;
        bus.WLAST = 1'b0;
        bus.BREADY = 1'b1;
        exp_id = (wq.size() > 0) ? wq.pop_front() : '0;
        tests_run++;
        if (bus.BVALID !== 1'b1 || bus.BID !== exp_id) begin
            tests_failed++;
            $display("[TB] FAIL aw_stall_bid: got bvalid=%b bid=%h expected 1 %h", bus.BVALID, bus.BID, exp_id);
        end
        @(negedge clk);
        bus.BREADY = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        logic ok;
        logic stayed_idle;
        bus.ARID = 8'h66;
        bus.ARLEN = 4'd7;
        bus.ARVALID = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.ARREADY) begin ok = 1'b1; @(negedge clk); break; end
            @(negedge clk);
        end
        bus.ARVALID = 1'b0;
        bus.RREADY = 1'b1;
        @(negedge clk);
        tests_run++;
        if (!ok || bus.RVALID !== 1'b1 || bus.RLAST !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_burst_beat2: got ok=%b rvalid=%b rlast=%b expected 1 1 0", ok, bus.RVALID, bus.RLAST);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.RVALID !== 1'b0 || bus.ARREADY !== 1'b1 || bus.RID !== '0) begin
            tests_failed++;
            $display("[TB] FAIL mid_burst_reset: got rvalid=%b arready=%b rid=%h expected 0 1 00", bus.RVALID, bus.ARREADY, bus.RID);
        end
        @(negedge clk);
        rst = 1'b0;
        stayed_idle = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.RVALID !== 1'b0) stayed_idle = 1'b0;
        end
        tests_run++;
        if (!stayed_idle) begin
            tests_failed++;
            $display("[TB] FAIL mid_burst_no_beats: got rvalid=1 after release, expected 0");
        end
        bus.RREADY = 1'b0;
    endtask

`ifdef AXI_DS_ERRCNT_EN
    task automatic test_err_cnt();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_write(8'h01, 1, 0);
        run_write(8'h02, 3, 0);
        run_write(8'h03, 1, 2);
        run_read(8'h04, 4'd0, 1'b0);
        run_read(8'h05, 4'd2, 1'b1);
        tests_run++;
        if (err_cnt !== 16'd5) begin
            tests_failed++;
            $display("[TB] FAIL err_cnt_count: got %0d expected 5", err_cnt);
        end
        force dut.err_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.err_cnt_q;
        @(negedge clk);
        run_write(8'h06, 1, 0);
        run_read(8'h07, 4'd0, 1'b0);
        tests_run++;
        if (err_cnt !== 16'hFFFF) begin
            tests_failed++;
            $display("[TB] FAIL err_cnt_saturate: got %h expected ffff", err_cnt);
        end
    endtask
`endif

    initial begin
        init_bus();
        test_reset();
        test_single_write();
        test_read_burst();
        test_backpressure();
        test_overlap();
        test_aw_stall();
        test_reset_mid_burst();
`ifdef AXI_DS_ERRCNT_EN
        test_err_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
